display_arbiter: RTL and testbench

- Shares the single four-digit seven-segment display between two independent requesters using request/grant.
- Drives the 16-bit packed-nibble value into SevenSegFourDig: digit 0 is in[3:0], digit 3 is in[15:12].
- Guarantees each granted requester a minimum on-screen hold time.
- Serves requesters round-robin and shows a fixed idle pattern when nobody owns the display.

---
 rtl/display_arbiter.sv | 129 ++++++++++++
 tb/tb_display_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/display_arbiter.sv
// display_arbiter
// Round-robin owner selection for the shared four-digit seven-segment display.
// Two level-sensitive requesters compete for the display. Once a requester is
// granted, it keeps the display for at least HOLD_CYCLES cycles. dispValue is
// registered and is fed straight into SevenSegFourDig.in. While nobody owns the
// display, it shows IDLE_VALUE.
module display_arbiter #(
    parameter int          HOLD_CYCLES = 50000000,
    parameter int          CNT_W       = 26,
    parameter logic [15:0] IDLE_VALUE  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [15:0] data0,
    input  logic        req1,
    input  logic [15:0] data1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [15:0] dispValue,
    output logic        holdDone
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // Terminal count of the hold counter; the counter saturates here.
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    // Last requester granted (0 or 1). Reset to 1 so that requester 0 wins the first tie.
    logic             last_gnt;

    // Gating with the owned states keeps holdDone low in IDLE, including when HOLD_CYCLES is 1.
    assign holdDone = (state != IDLE) && (hold_cnt == HOLD_MAX);

    // Arbitration FSM: the grant, display data and hold counter all update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            dispValue <= IDLE_VALUE;
            hold_cnt  <= '0;
            last_gnt  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 && (!req1 || last_gnt)) begin
                        state     <= OWN0;
                        gnt0      <= 1'b1;
                        gnt1      <= 1'b0;
                        dispValue <= data0;
                        hold_cnt  <= '0;
                        last_gnt  <= 1'b0;
                    end else if (req1) begin
                        state     <= OWN1;
                        gnt0      <= 1'b0;
                        gnt1      <= 1'b1;
                        dispValue <= data1;
                        hold_cnt  <= '0;
                        last_gnt  <= 1'b1;
                    end else begin
                        dispValue <= IDLE_VALUE;
                    end
                end

                OWN0: begin
                    if (!holdDone) begin
                        // The hold time is not over yet, so ownership is kept even if req0 drops.
                        hold_cnt <= hold_cnt + CNT_W'(1);
                        if (req0) dispValue <= data0;
                    end else if (req1) begin
                        // Hand over directly to requester 1, with no gap cycle.
                        state     <= OWN1;
                        gnt0      <= 1'b0;
                        gnt1      <= 1'b1;
                        dispValue <= data1;
                        hold_cnt  <= '0;
                        last_gnt  <= 1'b1;
                    end else if (!req0) begin
                        state     <= IDLE;
                        gnt0      <= 1'b0;
                        gnt1      <= 1'b0;
                        dispValue <= IDLE_VALUE;
                        hold_cnt  <= '0;
                    end else begin
                        dispValue <= data0;
                    end
                end

                OWN1: begin
                    if (!holdDone) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                        if (req1) dispValue <= data1;
                    end else if (req0) begin
                        state     <= OWN0;
                        gnt0      <= 1'b1;
                        gnt1      <= 1'b0;
                        dispValue <= data0;
                        hold_cnt  <= '0;
                        last_gnt  <= 1'b0;
                    end else if (!req1) begin
                        state     <= IDLE;
                        gnt0      <= 1'b0;
                        gnt1      <= 1'b0;
                        dispValue <= IDLE_VALUE;
                        hold_cnt  <= '0;
                    end else begin
                        dispValue <= data1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    gnt0      <= 1'b0;
                    gnt1      <= 1'b0;
                    dispValue <= IDLE_VALUE;
                    hold_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter
// Bench for display_arbiter with HOLD_CYCLES=4 and IDLE_VALUE=16'h3210.
// It applies a table of vectors and then a few hand-written sequences.
// Expected outputs are queued when each stimulus is driven and are checked
// one cycle later.
module tb_display_arbiter;

    localparam int          HOLD   = 4;
    localparam logic [15:0] IDLE_V = 16'h3210;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [15:0] data0, data1;
    logic        gnt0, gnt1, holdDone;
    logic [15:0] dispValue;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        g0;
        logic        g1;
        logic [15:0] disp;
        logic        hd;
        string       name;
    } exp_t;

    typedef struct {
        logic        r0;
        logic [15:0] d0;
        logic        r1;
        logic [15:0] d1;
        logic        g0;
        logic        g1;
        logic [15:0] disp;
        logic        hd;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[13];

    display_arbiter #(
        .HOLD_CYCLES(HOLD),
        .CNT_W      (3),
        .IDLE_VALUE (IDLE_V)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .data0    (data0),
        .req1     (req1),
        .data1    (data1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .dispValue(dispValue),
        .holdDone (holdDone)
    );

    always #5 clk = ~clk;

    task automatic compare(input exp_t e);
        checks++;
        if (gnt0 !== e.g0 || gnt1 !== e.g1 || dispValue !== e.disp || holdDone !== e.hd) begin
            errors++;
            $display("FAIL %s: got gnt0=%b gnt1=%b disp=%h hd=%b, want gnt0=%b gnt1=%b disp=%h hd=%b",
                     e.name, gnt0, gnt1, dispValue, holdDone, e.g0, e.g1, e.disp, e.hd);
        end
    endtask

    // Drive one cycle of stimulus and queue the outputs expected after the next edge.
    task automatic step(input logic r0, input logic [15:0] d0, input logic r1, input logic [15:0] d1,
                        input logic g0, input logic g1, input logic [15:0] disp, input logic hd,
                        input string nm);
        exp_t e;
        req0 = r0; data0 = d0; req1 = r1; data1 = d1;
        e.g0 = g0; e.g1 = g1; e.disp = disp; e.hd = hd; e.name = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare(sb.pop_front());
    endtask

    task automatic do_reset(input string nm);
        exp_t e;
        rst = 1'b1; req0 = 0; req1 = 0; data0 = '0; data1 = '0;
        repeat (2) @(posedge clk);
        #1;
        e.g0 = 0; e.g1 = 0; e.disp = IDLE_V; e.hd = 0; e.name = nm;
        compare(e);
        rst = 1'b0;
    endtask

    initial begin
        exp_t e;

        // Vectors, applied from reset. Each row holds {r0,d0,r1,d1} and the outputs expected after that edge.
        vecs[0]  = '{0, 16'h0000, 0, 16'h0000, 0, 0, 16'h3210, 0};
        vecs[1]  = '{0, 16'h0000, 0, 16'h0000, 0, 0, 16'h3210, 0};
        vecs[2]  = '{1, 16'h0123, 0, 16'h0000, 1, 0, 16'h0123, 0};
        vecs[3]  = '{1, 16'h0321, 0, 16'h0000, 1, 0, 16'h0321, 0};
        vecs[4]  = '{0, 16'h0555, 0, 16'h0000, 1, 0, 16'h0321, 0};
        vecs[5]  = '{0, 16'h0555, 0, 16'h0000, 1, 0, 16'h0321, 1};
        vecs[6]  = '{0, 16'h0000, 0, 16'h0000, 0, 0, 16'h3210, 0};
        vecs[7]  = '{1, 16'hAAAA, 1, 16'hBBBB, 0, 1, 16'hBBBB, 0};
        vecs[8]  = '{1, 16'hAAAA, 1, 16'hBBBB, 0, 1, 16'hBBBB, 0};
        vecs[9]  = '{1, 16'hAAAA, 1, 16'hBBBC, 0, 1, 16'hBBBC, 0};
        vecs[10] = '{1, 16'hAAAA, 1, 16'hBBBC, 0, 1, 16'hBBBC, 1};
        vecs[11] = '{1, 16'hAAAA, 1, 16'hBBBC, 1, 0, 16'hAAAA, 0};
        vecs[12] = '{0, 16'hAAAA, 1, 16'hBBBC, 1, 0, 16'hAAAA, 0};

        do_reset("reset_state");
        for (int i = 0; i < 10; i++)
            step(0, 16'h0000, 0, 16'h0000, 0, 0, IDLE_V, 0, "idle_no_req");
        for (int i = 0; i < 13; i++)
            step(vecs[i].r0, vecs[i].d0, vecs[i].r1, vecs[i].d1,
                 vecs[i].g0, vecs[i].g1, vecs[i].disp, vecs[i].hd, $sformatf("vec%0d", i));

        // Both requesters raise their requests straight out of reset: requester 0 first, then owners alternate every HOLD cycles.
        do_reset("reset_b");
        for (int k = 0; k < 16; k++) begin
            if (((k / HOLD) % 2) == 0)
                step(1, 16'h1111, 1, 16'h2222, 1, 0, 16'h1111, (k % HOLD) == HOLD - 1, "alternate");
            else
                step(1, 16'h1111, 1, 16'h2222, 0, 1, 16'h2222, (k % HOLD) == HOLD - 1, "alternate");
            checks++;
            if (gnt0 && gnt1) begin
                errors++;
                $display("FAIL both_grants: got gnt0=%b gnt1=%b, want at most one high", gnt0, gnt1);
            end
        end

        // A lone owner keeps the grant and holdDone saturates; a new requester then takes over on the next edge.
        do_reset("reset_c");
        for (int k = 0; k < 20; k++)
            step(1, 16'h5A5A, 0, 16'h0000, 1, 0, 16'h5A5A, k >= HOLD - 1, "sole_owner");
        step(1, 16'h5A5A, 1, 16'hA5A5, 0, 1, 16'hA5A5, 0, "takeover");

        // Reset is asserted mid-grant (holdCnt=2) and must act without waiting for a clock edge.
        do_reset("reset_d");
        for (int k = 0; k < 3; k++)
            step(1, 16'h0F0F, 0, 16'h0000, 1, 0, 16'h0F0F, 0, "pre_reset");
        #2;
        rst = 1'b1;
        #1;
        e.g0 = 0; e.g1 = 0; e.disp = IDLE_V; e.hd = 0; e.name = "async_reset";
        compare(e);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1, 16'h0F0F, 1, 16'hF0F0, 1, 0, 16'h0F0F, 0, "post_reset_tie");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
